// File: rtl/if_else_dispatch.sv
// Split side of the if/else datapath: routes each operand word to the if- or
// else-branch FIFO by the selector condition, tagging it with a sequence number.

module if_else_dispatch_fifo #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEQ_W-1:0]  i_seq,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [SEQ_W-1:0]  o_seq,
  output logic              o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              w_push;
  logic              w_pop;

  assign o_valid = (r_occ != '0);
  assign o_full  = (r_occ == OCC_W'(DEPTH));
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && o_valid && !i_flush;

  // Head is forced to zero when empty so idle outputs never show stale words.
  assign o_data = o_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_seq  = o_valid ? r_mem_seq[r_rd_ptr]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_data;
      r_mem_seq[r_wr_ptr]  <= i_seq;
    end
  end

endmodule

module if_else_dispatch #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4,
  parameter int          SEQ_W     = 8,
  parameter logic [31:0] COND_MASK = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       input_bit,
  input  logic [DATA_W-1:0] in_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  output logic [SEQ_W-1:0]  if_seq,
  output logic              else_valid,
  input  logic              else_ready,
  output logic [DATA_W-1:0] else_data,
  output logic [SEQ_W-1:0]  else_seq,
  output logic [15:0]       if_count,
  output logic [15:0]       else_count
);

  logic [SEQ_W-1:0] r_seq;
  logic [15:0]      r_if_count;
  logic [15:0]      r_else_count;
  logic             w_cond;
  logic             w_accept;
  logic             w_if_full;
  logic             w_else_full;

  assign w_cond   = |(input_bit & COND_MASK);
  // Ready looks only at registered occupancy; a pop while full frees space next cycle.
  assign in_ready = !w_if_full && !w_else_full;
  assign w_accept = in_valid && in_ready && !flush;

  assign if_count   = r_if_count;
  assign else_count = r_else_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq        <= '0;
      r_if_count   <= '0;
      r_else_count <= '0;
    end else if (flush) begin
      r_seq <= '0;
    end else if (w_accept) begin
      r_seq <= r_seq + SEQ_W'(1);
      if (w_cond) r_if_count   <= r_if_count + 16'd1;
      else        r_else_count <= r_else_count + 16'd1;
    end
  end

  if_else_dispatch_fifo #(
    .DATA_W (DATA_W),
    .SEQ_W  (SEQ_W),
    .DEPTH  (DEPTH)
  ) u_if_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_push  (w_accept && w_cond),
    .i_data  (in_data),
    .i_seq   (r_seq),
    .i_pop   (if_ready),
    .o_valid (if_valid),
    .o_data  (if_data),
    .o_seq   (if_seq),
    .o_full  (w_if_full)
  );

  if_else_dispatch_fifo #(
    .DATA_W (DATA_W),
    .SEQ_W  (SEQ_W),
    .DEPTH  (DEPTH)
  ) u_else_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_push  (w_accept && !w_cond),
    .i_data  (in_data),
    .i_seq   (r_seq),
    .i_pop   (else_ready),
    .o_valid (else_valid),
    .o_data  (else_data),
    .o_seq   (else_seq),
    .o_full  (w_else_full)
  );

endmodule

// File: tb/tb_if_else_dispatch.sv
// Bench for if_else_dispatch: queue-based reference model of the two branches,
// scenario tasks compare DUT heads, handshakes and counters against it.

module tb_if_else_dispatch;

  localparam int          DATA_W    = 32;
  localparam int          DEPTH     = 4;
  localparam int          SEQ_W     = 8;
  localparam logic [31:0] COND_MASK = 32'h0000_0001;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       input_bit;
  logic [DATA_W-1:0] in_data;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_data;
  logic [SEQ_W-1:0]  if_seq;
  logic              else_valid;
  logic              else_ready;
  logic [DATA_W-1:0] else_data;
  logic [SEQ_W-1:0]  else_seq;
  logic [15:0]       if_count;
  logic [15:0]       else_count;

  int checks;
  int failures;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [SEQ_W-1:0]  s;
  } ent_t;

  ent_t if_q[$];
  ent_t el_q[$];
  int   m_seq;
  int   m_ifc;
  int   m_elc;

  if_else_dispatch #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .SEQ_W     (SEQ_W),
    .COND_MASK (COND_MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input_bit  (input_bit),
    .in_data    (in_data),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_data    (if_data),
    .if_seq     (if_seq),
    .else_valid (else_valid),
    .else_ready (else_ready),
    .else_data  (else_data),
    .else_seq   (else_seq),
    .if_count   (if_count),
    .else_count (else_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_cond(input logic [31:0] b);
    return (b & COND_MASK) != 32'h0;
  endfunction

  // Advance one clock edge (called at a falling edge) and apply the
  // branch rules to the model queues.
  task automatic step();
    bit   rdy;
    ent_t e;
    rdy = (if_q.size() < DEPTH) && (el_q.size() < DEPTH);
    @(posedge clk);
    if (flush) begin
      if_q.delete();
      el_q.delete();
      m_seq = 0;
    end else begin
      if (if_ready && if_q.size() > 0) void'(if_q.pop_front());
      if (else_ready && el_q.size() > 0) void'(el_q.pop_front());
      if (in_valid && rdy) begin
        e.d = in_data;
        e.s = SEQ_W'(m_seq);
        if (m_cond(input_bit)) begin
          if_q.push_back(e);
          m_ifc = (m_ifc + 1) % 65536;
        end else begin
          el_q.push_back(e);
          m_elc = (m_elc + 1) % 65536;
        end
        m_seq = (m_seq + 1) % (1 << SEQ_W);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    flush      = 1'b0;
    if_ready   = 1'b1;
    else_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (if_valid !== 1'b0 || else_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: if_valid=%b else_valid=%b required 0/0", if_valid, else_valid);
    end
    checks++;
    if (if_data !== '0 || if_seq !== '0 || else_data !== '0 || else_seq !== '0) begin
      failures++;
      $display("FAIL reset_data: if=%h/%h else=%h/%h required zeros", if_data, if_seq, else_data, else_seq);
    end
    checks++;
    if (if_count !== 16'd0 || else_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count: if=%0d else=%0d required 0/0", if_count, else_count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [31:0] dat [4];
    logic [31:0] obs_if_d[$];
    logic [31:0] obs_el_d[$];
    int          obs_if_s[$];
    int          obs_el_s[$];
    dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33; dat[3] = 32'h44;
    if_ready   = 1'b1;
    else_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid  = (i < 4);
      in_data   = (i < 4) ? dat[i] : 32'h0;
      input_bit = (i < 4 && (i % 2) == 0) ? 32'h1 : 32'h0;
      #1;
      if (if_valid)   begin obs_if_d.push_back(if_data);   obs_if_s.push_back(int'(if_seq));   end
      if (else_valid) begin obs_el_d.push_back(else_data); obs_el_s.push_back(int'(else_seq)); end
      step();
    end
    checks++;
    if (obs_if_d.size() != 2 || obs_if_d[0] !== 32'h11 || obs_if_s[0] != 0 ||
        obs_if_d[1] !== 32'h33 || obs_if_s[1] != 2) begin
      failures++;
      $display("FAIL alt_if_stream: got %0d words first=%h/%0d required 11/0,33/2",
               obs_if_d.size(), (obs_if_d.size() > 0) ? obs_if_d[0] : 32'hx,
               (obs_if_s.size() > 0) ? obs_if_s[0] : -1);
    end
    checks++;
    if (obs_el_d.size() != 2 || obs_el_d[0] !== 32'h22 || obs_el_s[0] != 1 ||
        obs_el_d[1] !== 32'h44 || obs_el_s[1] != 3) begin
      failures++;
      $display("FAIL alt_else_stream: got %0d words first=%h/%0d required 22/1,44/3",
               obs_el_d.size(), (obs_el_d.size() > 0) ? obs_el_d[0] : 32'hx,
               (obs_el_s.size() > 0) ? obs_el_s[0] : -1);
    end
    checks++;
    if (if_count !== 16'd2 || else_count !== 16'd2) begin
      failures++;
      $display("FAIL alt_counts: if=%0d else=%0d required 2/2", if_count, else_count);
    end
  endtask

  task automatic test_fill_if();
    int saved_ifc;
    drain();
    if_ready   = 1'b0;
    else_ready = 1'b1;
    input_bit  = 32'h0000_0003;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + i;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready_before_full: word %0d in_ready=%b required 1", i, in_ready);
      end
      step();
    end
    in_data   = 32'hA000_00FF;
    saved_ifc = m_ifc;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || if_count !== 16'(saved_ifc)) begin
        failures++;
        $display("FAIL fill_held: in_ready=%b if_count=%0d required 0/%0d", in_ready, if_count, saved_ifc);
      end
      step();
    end
    if_ready = 1'b1;
    #1;
    checks++;
    if (if_data !== if_q[0].d || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_pop_cycle: if_data=%h in_ready=%b required %h/0", if_data, in_ready, if_q[0].d);
    end
    step();
    if_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready_restore: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    if_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1;
      checks++;
      if (if_valid !== (if_q.size() != 0) ||
          (if_q.size() != 0 && (if_data !== if_q[0].d || if_seq !== if_q[0].s))) begin
        failures++;
        $display("FAIL fill_drain: valid=%b data=%h seq=%0d required valid=%b", if_valid, if_data,
                 if_seq, if_q.size() != 0);
      end
      step();
    end
    checks++;
    if (if_count !== 16'(saved_ifc + 1)) begin
      failures++;
      $display("FAIL fill_count: if_count=%0d required %0d", if_count, saved_ifc + 1);
    end
  endtask

  task automatic test_push_pop();
    drain();
    else_ready = 1'b0;
    input_bit  = 32'hFFFF_FFFE;
    in_valid   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom;
      step();
    end
    else_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      #1;
      checks++;
      if (el_q.size() != 2 || else_valid !== 1'b1 || in_ready !== 1'b1 ||
          else_data !== el_q[0].d || else_seq !== el_q[0].s) begin
        failures++;
        $display("FAIL pushpop_head: cyc %0d valid=%b data=%h seq=%0d required 1/%h/%0d", i,
                 else_valid, else_data, else_seq, el_q[0].d, el_q[0].s);
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (else_valid !== (el_q.size() != 0) ||
          (el_q.size() != 0 && else_data !== el_q[0].d)) begin
        failures++;
        $display("FAIL pushpop_drain: valid=%b data=%h required valid=%b", else_valid, else_data,
                 el_q.size() != 0);
      end
      step();
    end
  endtask

  task automatic test_seq_wrap();
    int  obs[$];
    bit  ok;
    drain();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 262; i++) begin
      in_valid  = (i < 260);
      input_bit = $urandom;
      in_data   = $urandom;
      #1;
      if (if_valid)   obs.push_back(int'(if_seq));
      if (else_valid) obs.push_back(int'(else_seq));
      step();
    end
    checks++;
    if (obs.size() != 260) begin
      failures++;
      $display("FAIL wrap_count: got %0d tags required 260", obs.size());
    end else begin
      ok = 1'b1;
      for (int i = 0; i < 260; i++) if (obs[i] != i % 256) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wrap_consecutive: tags not consecutive mod 256");
      end
      checks++;
      if (obs[255] != 255 || obs[256] != 0) begin
        failures++;
        $display("FAIL wrap_edge: got %0d,%0d required 255,0", obs[255], obs[256]);
      end
      checks++;
      if (obs[256] != 0 || obs[257] != 1 || obs[258] != 2 || obs[259] != 3) begin
        failures++;
        $display("FAIL wrap_tail: got %0d %0d %0d %0d required 0 1 2 3", obs[256], obs[257],
                 obs[258], obs[259]);
      end
    end
  endtask

  task automatic test_flush();
    int saved_ifc;
    int saved_elc;
    drain();
    if_ready  = 1'b0;
    input_bit = 32'h1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hF000_0000 + i;
      step();
    end
    saved_ifc = m_ifc;
    saved_elc = m_elc;
    flush   = 1'b1;
    in_data = 32'hDEAD_BEEF;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || else_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid: if_valid=%b else_valid=%b required 0/0", if_valid, else_valid);
    end
    checks++;
    if (if_count !== 16'(saved_ifc) || else_count !== 16'(saved_elc)) begin
      failures++;
      $display("FAIL flush_counts: if=%0d else=%0d required %0d/%0d", if_count, else_count,
               saved_ifc, saved_elc);
    end
    in_valid = 1'b1;
    in_data  = 32'h0BAD_F00D;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_seq !== 8'd0 || if_data !== 32'h0BAD_F00D ||
        if_count !== 16'(saved_ifc + 1)) begin
      failures++;
      $display("FAIL flush_next_accept: valid=%b seq=%0d data=%h count=%0d required 1/0/0badf00d/%0d",
               if_valid, if_seq, if_data, if_count, saved_ifc + 1);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      input_bit  = $urandom;
      in_data    = $urandom;
      if_ready   = ($urandom_range(0, 2) == 0);
      else_ready = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (in_ready !== ((if_q.size() < DEPTH) && (el_q.size() < DEPTH)) ||
          if_valid !== (if_q.size() != 0) || else_valid !== (el_q.size() != 0) ||
          (if_q.size() != 0 && (if_data !== if_q[0].d || if_seq !== if_q[0].s)) ||
          (el_q.size() != 0 && (else_data !== el_q[0].d || else_seq !== el_q[0].s)) ||
          if_count !== 16'(m_ifc) || else_count !== 16'(m_elc)) begin
        failures++;
        $display("FAIL random_cyc%0d: rdy=%b ifv=%b %h/%0d elv=%b %h/%0d cnt=%0d/%0d model occ=%0d/%0d cnt=%0d/%0d",
                 i, in_ready, if_valid, if_data, if_seq, else_valid, else_data, else_seq,
                 if_count, else_count, if_q.size(), el_q.size(), m_ifc, m_elc);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    drain();
    if_ready   = 1'b0;
    else_ready = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      input_bit = i % 2;
      in_data   = $urandom;
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b1 || else_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: if_valid=%b else_valid=%b required 1/1", if_valid, else_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || else_valid !== 1'b0 || if_count !== 16'd0 || else_count !== 16'd0) begin
      failures++;
      $display("FAIL areset_immediate: valids=%b/%b counts=%0d/%0d required 0/0 0/0", if_valid,
               else_valid, if_count, else_count);
    end
    if_q.delete();
    el_q.delete();
    m_seq = 0;
    m_ifc = 0;
    m_elc = 0;
    @(negedge clk);
    reset      = 1'b1;
    if_ready   = 1'b1;
    else_ready = 1'b1;
    in_valid   = 1'b1;
    input_bit  = 32'h0;
    in_data    = 32'h5555_AAAA;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (else_valid !== 1'b1 || else_seq !== 8'd0 || else_data !== 32'h5555_AAAA ||
        else_count !== 16'd1 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_restart: valid=%b seq=%0d data=%h count=%0d required 1/0/5555aaaa/1",
               else_valid, else_seq, else_data, else_count);
    end
    step();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_seq      = 0;
    m_ifc      = 0;
    m_elc      = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    input_bit  = 32'h0;
    in_data    = '0;
    if_ready   = 1'b0;
    else_ready = 1'b0;
    test_reset();
    test_alternate();
    test_fill_if();
    test_push_pop();
    test_seq_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_else_dispatch.md
Name: if_else_dispatch

Overview:
- Split side of the if/else datapath: accepts one stream of 32-bit operand words plus a 32-bit selector word, and routes each word to either the if-section or the else-section.
- The choice is made by evaluating the if-condition on the selector.
- Each branch has its own small FIFO and valid/ready output. Every word carries a sequence tag so the downstream combine stage can restore the original order.
- Sits between the input bit stream and the per-branch if/else compute blocks.

Parameters:
- DATA_W, 32, operand word width.
- DEPTH, 4, entries per branch FIFO; power of two, minimum 2.
- SEQ_W, 8, sequence tag width; wraps modulo 2^SEQ_W.
- COND_MASK, 32'h0000_0001, selector bits tested by the if-condition.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both FIFOs and seq counter; counters kept.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept input this cycle.
- input_bit  input  32  selector word, sampled with in_data.
- in_data  input  DATA_W  operand word.
- if_valid  output  1  if-branch head valid.
- if_ready  input  1  if-section consumes head.
- if_data  output  DATA_W  if-branch head word.
- if_seq  output  SEQ_W  tag of if-branch head.
- else_valid  output  1  else-branch head valid.
- else_ready  input  1  else-section consumes head.
- else_data  output  DATA_W  else-branch head word.
- else_seq  output  SEQ_W  tag of else-branch head.
- if_count  output  16  words routed to if-branch, wraps at 2^16.
- else_count  output  16  words routed to else-branch, wraps at 2^16.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, occupancies, sequence counter, if_count and else_count go to 0.
  - if_valid and else_valid go to 0; in_ready goes to 1 after release.
  - Data and seq outputs read 0.
  - Reset mid-transfer discards all queued words without emitting them.
- Condition: cond = |(input_bit & COND_MASK). cond=1 selects the if-branch, cond=0 the else-branch.
- Input handshake:
  - in_ready = !if_full && !else_full. It is registered-state only and never depends on in_valid or input_bit.
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - On a transfer: {in_data, seq} is written to the selected FIFO tail, seq increments mod 2^SEQ_W, and the selected branch counter increments.
- Output side, each branch:
  - Each branch is a first-word-fall-through FIFO.
  - *_valid = occupancy != 0. *_data and *_seq present the head entry.
  - A pop occurs on a rising edge with *_valid && *_ready.
  - Held data must stay stable while valid is high and ready is low.
- Latency: a word accepted at edge N is visible at its branch head in cycle N+1 if that FIFO was empty.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged and head advances correctly. This is legal at any non-full occupancy.
- Full: a FIFO at DEPTH entries deasserts in_ready for both branches, so no overflow occurs. A pop in that cycle reasserts in_ready the following cycle (no same-cycle pass-through).
- Empty: a pop with *_valid=0 is ignored and occupancy never underflows.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - seq wraps from 2^SEQ_W-1 to 0.
  - Counters wrap from 16'hFFFF to 0.
- Flush:
  - At the edge, both occupancies and seq go to 0, both valids drop, and any same-cycle push or pop is discarded.
  - Counters are unaffected.
  - Reset has priority over flush.
- Ordering: within a branch, words leave in acceptance order. Across branches, the seq tags are strictly consecutive in acceptance order.

Test Plan:
- Reset then alternate cond: feed data 0x11, 0x22, 0x33, 0x44 with input_bit 1,0,1,0 and both readies high -> if branch emits 0x11/seq0 and 0x33/seq2; else branch emits 0x22/seq1 and 0x44/seq3; if_count=2, else_count=2.
- Fill the if-branch: if_ready=0, push 4 words with cond=1 -> in_ready drops after the 4th accept; a 5th in_valid is held unaccepted; raising if_ready for 1 cycle restores in_ready in the next cycle.
- Simultaneous push/pop: hold 2 entries in the else-branch with else_ready=1 and in_valid=1 with cond=0 every cycle for 10 cycles -> occupancy stays 2 and output order matches input.
- Seq wrap: with SEQ_W=8, stream 260 words -> tags run 255 then 0, and the last four tags are 0..3.
- Flush: with 3 if-entries queued, assert flush together with in_valid -> next cycle if_valid=0, the word is not queued, the following accept gets seq 0, and counters keep their prior values.
- Async reset mid-stream: drop reset between clock edges with both FIFOs non-empty -> valids fall to 0 immediately without waiting for clk, and counters read 0.
